// File: rtl/router_fsm.sv
// Packet-sequencing controller for the 1x3 router: decodes the header destination,
// waits for the selected FIFO, and steps header/payload/parity loading with stalls.
module router_fsm #(
    parameter int ADDR_WIDTH = 2,
    parameter int NUM_DEST   = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  pkt_valid,
    input  logic [ADDR_WIDTH-1:0] data_in,
    input  logic                  fifo_full,
    input  logic                  fifo_empty_0,
    input  logic                  fifo_empty_1,
    input  logic                  fifo_empty_2,
    input  logic                  soft_reset_0,
    input  logic                  soft_reset_1,
    input  logic                  soft_reset_2,
    input  logic                  parity_done,
    input  logic                  low_packet_valid,
    output logic [ADDR_WIDTH-1:0] dest_sel,
    output logic                  detect_add,
    output logic                  lfd_state,
    output logic                  ld_state,
    output logic                  laf_state,
    output logic                  full_state,
    output logic                  rst_int_reg,
    output logic                  write_enb_reg,
    output logic                  busy
);

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        WAIT_TILL_EMPTY    = 3'd1,
        LOAD_FIRST_DATA    = 3'd2,
        LOAD_DATA          = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        LOAD_PARITY        = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } state_t;

    state_t state;
    state_t next_state;

    logic [2:0] empty_vec;
    logic [2:0] soft_vec;
    logic       addr_ok;
    logic       hdr_empty;
    logic       sel_empty;
    logic       sel_soft;

    assign empty_vec = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
    assign soft_vec  = {soft_reset_2, soft_reset_1, soft_reset_0};
    assign addr_ok   = (int'(data_in) < NUM_DEST);

    // Out-of-range addresses never index the flag vectors.
    assign hdr_empty = addr_ok && empty_vec[data_in];
    assign sel_empty = (int'(dest_sel) < NUM_DEST) && empty_vec[dest_sel];
    assign sel_soft  = (int'(dest_sel) < NUM_DEST) && soft_vec[dest_sel];

    always_comb begin
        next_state = DECODE_ADDRESS;
        if (state != DECODE_ADDRESS && sel_soft) begin
            next_state = DECODE_ADDRESS;
        end else begin
            case (state)
                DECODE_ADDRESS: begin
                    if (pkt_valid && addr_ok)
                        next_state = hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                    else
                        next_state = DECODE_ADDRESS;
                end
                WAIT_TILL_EMPTY:
                    next_state = sel_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                LOAD_FIRST_DATA:
                    next_state = LOAD_DATA;
                LOAD_DATA: begin
                    if (fifo_full)
                        next_state = FIFO_FULL_STATE;
                    else if (!pkt_valid)
                        next_state = LOAD_PARITY;
                    else
                        next_state = LOAD_DATA;
                end
                FIFO_FULL_STATE:
                    next_state = fifo_full ? FIFO_FULL_STATE : LOAD_AFTER_FULL;
                LOAD_AFTER_FULL: begin
                    if (parity_done)
                        next_state = DECODE_ADDRESS;
                    else if (low_packet_valid)
                        next_state = LOAD_PARITY;
                    else
                        next_state = LOAD_DATA;
                end
                LOAD_PARITY:
                    next_state = CHECK_PARITY_ERROR;
                CHECK_PARITY_ERROR:
                    next_state = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
                default:
                    next_state = DECODE_ADDRESS;
            endcase
        end
    end

    // Outputs are registered from the next state so they always match the state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= DECODE_ADDRESS;
            dest_sel      <= '0;
            detect_add    <= 1'b1;
            lfd_state     <= 1'b0;
            ld_state      <= 1'b0;
            laf_state     <= 1'b0;
            full_state    <= 1'b0;
            rst_int_reg   <= 1'b0;
            write_enb_reg <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state <= next_state;
            if (state == DECODE_ADDRESS && pkt_valid && addr_ok)
                dest_sel <= data_in;
            detect_add    <= (next_state == DECODE_ADDRESS);
            lfd_state     <= (next_state == LOAD_FIRST_DATA);
            ld_state      <= (next_state == LOAD_DATA);
            laf_state     <= (next_state == LOAD_AFTER_FULL);
            full_state    <= (next_state == FIFO_FULL_STATE);
            rst_int_reg   <= (next_state == CHECK_PARITY_ERROR);
            write_enb_reg <= (next_state == LOAD_DATA) || (next_state == LOAD_PARITY) ||
                             (next_state == LOAD_AFTER_FULL);
            busy          <= (next_state != DECODE_ADDRESS) && (next_state != LOAD_DATA);
        end
    end

endmodule

// File: tb/tb_router_fsm.sv
// Directed, table-driven bench for router_fsm: each record gives one cycle of inputs
// and the state/dest_sel expected after the following rising edge.
module tb_router_fsm;

    localparam int S_D   = 0;
    localparam int S_W   = 1;
    localparam int S_LFD = 2;
    localparam int S_LD  = 3;
    localparam int S_FF  = 4;
    localparam int S_LAF = 5;
    localparam int S_LP  = 6;
    localparam int S_CPE = 7;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       pkt_valid = 1'b0;
    logic [1:0] data_in = '0;
    logic       fifo_full = 1'b0;
    logic       fifo_empty_0 = 1'b0;
    logic       fifo_empty_1 = 1'b0;
    logic       fifo_empty_2 = 1'b0;
    logic       soft_reset_0 = 1'b0;
    logic       soft_reset_1 = 1'b0;
    logic       soft_reset_2 = 1'b0;
    logic       parity_done = 1'b0;
    logic       low_packet_valid = 1'b0;
    logic [1:0] dest_sel;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state;
    logic       rst_int_reg, write_enb_reg, busy;

    int checks = 0;
    int failures = 0;

    router_fsm dut (
        .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1),
        .fifo_empty_2(fifo_empty_2), .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1),
        .soft_reset_2(soft_reset_2), .parity_done(parity_done),
        .low_packet_valid(low_packet_valid), .dest_sel(dest_sel), .detect_add(detect_add),
        .lfd_state(lfd_state), .ld_state(ld_state), .laf_state(laf_state),
        .full_state(full_state), .rst_int_reg(rst_int_reg), .write_enb_reg(write_enb_reg),
        .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       rst;
        logic       pv;
        logic [1:0] din;
        logic       ff;
        logic [2:0] emp;
        logic [2:0] sr;
        logic       pd;
        logic       lpv;
        int         st;
        logic [1:0] dest;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic rst, input logic pv, input logic [1:0] din,
                                input logic ff, input logic [2:0] emp, input logic [2:0] sr,
                                input logic pd, input logic lpv, input int st,
                                input logic [1:0] dest);
        vec_t v;
        v.rst = rst; v.pv = pv; v.din = din; v.ff = ff; v.emp = emp; v.sr = sr;
        v.pd = pd; v.lpv = lpv; v.st = st; v.dest = dest;
        vecs.push_back(v);
    endfunction

    // Flag order: detect, lfd, ld, laf, full, rst_int, write_enb, busy.
    function automatic logic [7:0] exp_flags(input int st);
        case (st)
            S_D:     return 8'b1000_0000;
            S_W:     return 8'b0000_0001;
            S_LFD:   return 8'b0100_0001;
            S_LD:    return 8'b0010_0010;
            S_FF:    return 8'b0000_1001;
            S_LAF:   return 8'b0001_0011;
            S_LP:    return 8'b0000_0011;
            default: return 8'b0000_0101;
        endcase
    endfunction

    task automatic apply_stimulus(input vec_t v);
        @(negedge clock);
        reset = v.rst; pkt_valid = v.pv; data_in = v.din; fifo_full = v.ff;
        {fifo_empty_2, fifo_empty_1, fifo_empty_0} = v.emp;
        {soft_reset_2, soft_reset_1, soft_reset_0} = v.sr;
        parity_done = v.pd; low_packet_valid = v.lpv;
        @(posedge clock);
        #1;
    endtask

    task automatic check_output(input string name, input int st, input logic [1:0] dest);
        logic [9:0] act;
        logic [9:0] req;
        act = {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
               write_enb_reg, busy, dest_sel};
        req = {exp_flags(st), dest};
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s: flags/dest actual=%b required=%b", name, act, req);
        end
    endtask

    initial begin
        // Reset, then a clean packet to destination 1
        add(1,0,0,0,3'b000,0,0,0,S_D,0);
        add(1,0,0,0,3'b000,0,0,0,S_D,0);
        add(1,0,0,0,3'b000,0,0,0,S_D,0);
        add(0,1,1,0,3'b010,0,0,0,S_LFD,1);
        add(0,1,1,0,3'b010,0,0,0,S_LD,1);
        for (int i = 0; i < 4; i++) add(0,1,1,0,3'b010,0,0,0,S_LD,1);
        add(0,0,0,0,3'b010,0,0,0,S_LP,1);
        add(0,0,0,0,3'b010,0,0,0,S_CPE,1);
        add(0,0,0,0,3'b010,0,0,0,S_D,1);
        // Destination 2 busy for 5 cycles, then full/after-full handling
        for (int i = 0; i < 5; i++) add(0,1,2,0,3'b000,0,0,0,S_W,2);
        add(0,1,2,0,3'b100,0,0,0,S_LFD,2);
        add(0,1,2,0,3'b100,0,0,0,S_LD,2);
        for (int i = 0; i < 3; i++) add(0,1,2,1,3'b100,0,0,0,S_FF,2);
        add(0,1,2,0,3'b100,0,0,0,S_LAF,2);
        add(0,1,2,0,3'b100,0,0,0,S_LD,2);
        add(0,1,2,1,3'b100,0,0,0,S_FF,2);
        add(0,1,2,0,3'b100,0,0,0,S_LAF,2);
        add(0,0,2,0,3'b100,0,0,1,S_LP,2);
        add(0,0,2,0,3'b100,0,0,0,S_CPE,2);
        add(0,0,2,0,3'b100,0,0,0,S_D,2);
        // Invalid address 3 is ignored
        for (int i = 0; i < 4; i++) add(0,1,3,0,3'b111,0,0,0,S_D,2);
        // Soft resets: non-selected ignored, selected aborts
        add(0,1,0,0,3'b001,0,0,0,S_LFD,0);
        add(0,1,0,0,3'b001,0,0,0,S_LD,0);
        add(0,1,0,0,3'b001,3'b010,0,0,S_LD,0);
        add(0,1,0,0,3'b001,3'b001,0,0,S_D,0);
        // Reset during FIFO_FULL_STATE
        add(0,1,1,0,3'b010,0,0,0,S_LFD,1);
        add(0,1,1,0,3'b010,0,0,0,S_LD,1);
        add(0,1,1,1,3'b010,0,0,0,S_FF,1);
        add(1,1,1,1,3'b010,0,0,0,S_D,0);
        // pkt_valid drop together with full; parity_done exit from LAF
        add(0,1,0,0,3'b001,0,0,0,S_LFD,0);
        add(0,1,0,0,3'b001,0,0,0,S_LD,0);
        add(0,0,0,1,3'b001,0,0,0,S_FF,0);
        add(0,0,0,0,3'b001,0,0,0,S_LAF,0);
        add(0,0,0,0,3'b001,0,1,0,S_D,0);
        // Full after parity check, then soft reset out of FIFO_FULL_STATE
        add(0,1,2,0,3'b100,0,0,0,S_LFD,2);
        add(0,1,2,0,3'b100,0,0,0,S_LD,2);
        add(0,0,2,0,3'b100,0,0,0,S_LP,2);
        add(0,0,2,1,3'b100,0,0,0,S_CPE,2);
        add(0,0,2,1,3'b100,0,0,0,S_FF,2);
        add(0,0,2,1,3'b100,3'b100,0,0,S_D,2);
        add(0,0,1,0,3'b010,0,0,0,S_D,2);

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i]);
            check_output($sformatf("vec%0d", i), vecs[i].st, vecs[i].dest);
        end

        // Hand sequence: soft reset while waiting for an empty FIFO
        begin
            vec_t v;
            v.rst = 0; v.pv = 1; v.din = 1; v.ff = 0; v.emp = 3'b000; v.sr = 0;
            v.pd = 0; v.lpv = 0; v.st = S_W; v.dest = 1;
            apply_stimulus(v);
            check_output("wait_entry", S_W, 1);
            v.sr = 3'b101;
            apply_stimulus(v);
            check_output("wait_other_soft", S_W, 1);
            v.sr = 3'b010;
            apply_stimulus(v);
            check_output("wait_sel_soft", S_D, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
